// File: rtl/ccd_bayer_rgb.sv
// Bayer-to-RGB demosaic: one half-resolution RGB pixel per completed 2x2 quad.
// Two-stage pipeline: line-buffer read + input register, then green average + output register.
module ccd_bayer_rgb #(
   parameter int unsigned LINE_WIDTH = 1280,
   parameter int unsigned DATA_W     = 10
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [DATA_W-1:0] iDATA,
   input  logic              iDVAL,
   input  logic [10:0]       iX_Cont,
   input  logic [10:0]       iY_Cont,
   output logic [DATA_W-1:0] oRed,
   output logic [DATA_W-1:0] oGreen,
   output logic [DATA_W-1:0] oBlue,
   output logic [9:0]        oX_Cont,
   output logic [9:0]        oY_Cont,
   output logic              oDVAL
);

   localparam int unsigned AddrW      = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [11:0] LineWidthC = 12'(LINE_WIDTH);

   logic              inRange;
   logic              beatValid;
   logic [AddrW-1:0]  bufAddr;
   logic [DATA_W-1:0] lineBuf [LINE_WIDTH];
   logic [DATA_W-1:0] prevRowRd;

   logic              s1Val;
   logic              s1Odd;
   logic              s1Complete;
   logic [DATA_W-1:0] s1Data;
   logic [9:0]        s1X;
   logic [9:0]        s1Y;

   logic [DATA_W-1:0] holdCur;
   logic [DATA_W-1:0] holdPrev;
   logic [DATA_W:0]   greenSum;

   always_comb begin
      inRange   = ({1'b0, iX_Cont} < LineWidthC);
      beatValid = iDVAL && inRange;
      bufAddr   = iX_Cont[AddrW-1:0];
   end

   // Read and write in the same clock: the read sees the previous row's sample.
   always_ff @(posedge iCLK) begin
      if (beatValid) begin
         prevRowRd        <= lineBuf[bufAddr];
         lineBuf[bufAddr] <= iDATA;
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         s1Val      <= 1'b0;
         s1Odd      <= 1'b0;
         s1Complete <= 1'b0;
         s1Data     <= '0;
         s1X        <= '0;
         s1Y        <= '0;
      end else begin
         s1Val <= beatValid;
         if (beatValid) begin
            s1Odd      <= iX_Cont[0];
            s1Complete <= iX_Cont[0] & iY_Cont[0];
            s1Data     <= iDATA;
            s1X        <= iX_Cont[10:1];
            s1Y        <= iY_Cont[10:1];
         end
      end
   end

   always_comb begin
      greenSum = {1'b0, holdPrev} + {1'b0, s1Data};
   end

   // Even-column beats refresh the holds; odd-column beats on odd rows close a quad.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         holdCur  <= '0;
         holdPrev <= '0;
         oRed     <= '0;
         oGreen   <= '0;
         oBlue    <= '0;
         oX_Cont  <= '0;
         oY_Cont  <= '0;
         oDVAL    <= 1'b0;
      end else begin
         oDVAL <= 1'b0;
         if (s1Val) begin
            if (!s1Odd) begin
               holdCur  <= s1Data;
               holdPrev <= prevRowRd;
            end else if (s1Complete) begin
               oRed    <= prevRowRd;
               oGreen  <= greenSum[DATA_W:1];
               oBlue   <= holdCur;
               oX_Cont <= s1X;
               oY_Cont <= s1Y;
               oDVAL   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ccd_bayer_rgb.sv
// Directed bench for ccd_bayer_rgb: hand-computed quads, latency, gaps, range and reset.
module tb_ccd_bayer_rgb;

   logic       iCLK = 1'b0;
   logic       iRST;
   logic [9:0] iDATA;
   logic       iDVAL;
   logic [10:0] iX_Cont;
   logic [10:0] iY_Cont;
   logic [9:0] oRed;
   logic [9:0] oGreen;
   logic [9:0] oBlue;
   logic [9:0] oX_Cont;
   logic [9:0] oY_Cont;
   logic       oDVAL;

   int checks = 0;
   int errors = 0;

   ccd_bayer_rgb #(
      .LINE_WIDTH(1280),
      .DATA_W    (10)
   ) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iDATA  (iDATA),
      .iDVAL  (iDVAL),
      .iX_Cont(iX_Cont),
      .iY_Cont(iY_Cont),
      .oRed   (oRed),
      .oGreen (oGreen),
      .oBlue  (oBlue),
      .oX_Cont(oX_Cont),
      .oY_Cont(oY_Cont),
      .oDVAL  (oDVAL)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one beat for one clock; returns 1 time unit after the sampling edge.
   task automatic beat(input logic v, input int x, input int y, input int d);
      iDVAL   = v;
      iX_Cont = 11'(x);
      iY_Cont = 11'(y);
      iDATA   = 10'(d);
      @(posedge iCLK);
      #1;
   endtask

   task automatic idle();
      beat(1'b0, 0, 0, 0);
   endtask

   task automatic noPix(input string tag);
      chk(tag, 32'(oDVAL), 32'd0);
   endtask

   task automatic pix(input string tag, input int r, input int g, input int b,
                      input int x, input int y);
      chk({tag, "_dval"}, 32'(oDVAL), 32'd1);
      chk({tag, "_red"}, 32'(oRed), 32'(r));
      chk({tag, "_green"}, 32'(oGreen), 32'(g));
      chk({tag, "_blue"}, 32'(oBlue), 32'(b));
      chk({tag, "_x"}, 32'(oX_Cont), 32'(x));
      chk({tag, "_y"}, 32'(oY_Cont), 32'(y));
   endtask

   initial begin
      iRST = 1'b0;
      iDVAL = 1'b0;
      iX_Cont = '0;
      iY_Cont = '0;
      iDATA = '0;
      repeat (3) @(posedge iCLK);
      #1;
      chk("rst_dval", 32'(oDVAL), 32'd0);
      chk("rst_red", 32'(oRed), 32'd0);
      chk("rst_green", 32'(oGreen), 32'd0);
      chk("rst_blue", 32'(oBlue), 32'd0);
      chk("rst_x", 32'(oX_Cont), 32'd0);
      chk("rst_y", 32'(oY_Cont), 32'd0);
      iRST = 1'b1;
      idle();

      // Single quad: G1=100 R=200 B=300 G2=103
      beat(1'b1, 0, 0, 100); noPix("q0_r0x0");
      beat(1'b1, 1, 0, 200); noPix("q0_r0x1");
      beat(1'b1, 0, 1, 300); noPix("q0_r1x0");
      beat(1'b1, 1, 1, 103); noPix("q0_lat1");
      idle();                pix("q0", 200, 101, 300, 0, 0);
      idle();                noPix("q0_pulse");
      chk("q0_hold_red", 32'(oRed), 32'd200);
      chk("q0_hold_green", 32'(oGreen), 32'd101);

      // Rows 2/3, three quads: max values, contiguous pair, then gaps and out-of-range beats
      beat(1'b1, 0, 2, 1023); noPix("r2x0");
      beat(1'b1, 1, 2, 1023); noPix("r2x1");
      beat(1'b1, 2, 2, 10);   noPix("r2x2");
      beat(1'b1, 3, 2, 20);   noPix("r2x3");
      beat(1'b1, 4, 2, 7);    noPix("r2x4");
      beat(1'b1, 5, 2, 500);  noPix("r2x5");
      beat(1'b1, 0, 3, 1023); noPix("r3x0");
      beat(1'b1, 1, 3, 1023); noPix("r3x1");
      beat(1'b1, 2, 3, 30);   pix("qmax", 1023, 1023, 1023, 0, 1);
      beat(1'b1, 3, 3, 41);   noPix("no_consec");
      idle();                 pix("qb", 20, 25, 30, 1, 1);
      idle();                 noPix("gap1");
      idle();                 noPix("gap2");
      beat(1'b1, 1281, 3, 999); noPix("oor_odd");
      idle();                   noPix("oor_odd_lat");
      beat(1'b1, 4, 3, 0);      noPix("r3x4");
      beat(1'b1, 1280, 3, 999); noPix("oor_even");
      idle();                   noPix("gap3");
      beat(1'b1, 5, 3, 8);      noPix("r3x5");
      idle();                   pix("qc", 500, 7, 0, 2, 1);

      // Reset while the completing quad of rows 4/5 is in flight
      beat(1'b1, 0, 4, 1);
      beat(1'b1, 1, 4, 2);
      beat(1'b1, 0, 5, 3);
      beat(1'b1, 1, 5, 4);
      iRST = 1'b0;
      #1;
      chk("mid_rst_dval", 32'(oDVAL), 32'd0);
      chk("mid_rst_red", 32'(oRed), 32'd0);
      chk("mid_rst_green", 32'(oGreen), 32'd0);
      chk("mid_rst_x", 32'(oX_Cont), 32'd0);
      chk("mid_rst_y", 32'(oY_Cont), 32'd0);
      iDVAL = 1'b0;
      @(posedge iCLK);
      #1;
      noPix("mid_rst_hold");
      iRST = 1'b1;
      idle(); noPix("post_rst");

      // Next frame after reset
      beat(1'b1, 0, 0, 5);
      beat(1'b1, 1, 0, 6);
      beat(1'b1, 0, 1, 7);
      beat(1'b1, 1, 1, 9);  noPix("f2_lat1");
      idle();               pix("f2", 6, 7, 7, 0, 0);
      idle();               noPix("f2_pulse");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
